mem_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the rv32 core's instruction-fetch port and its load/store port.
- Serialises the two requesters through a small FSM and inserts the variable memory read latency.
- Drives a stall line so the core freezes PC and pipeline state until its access completes.
- Sits between core (pc/instr, addr_to_mem/be/mem_wen/data_to_mem/data_from_mem) and the unified RAM.

---
 rtl/rv_mem_pkg.sv | 12 +
 rtl/mem_arb_pick.sv | 18 +
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared FSM/owner encodings and default timing constants for the memory arbiter.
package rv_mem_pkg;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;
    localparam int MEM_LAT_DEF    = 1;
    localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: data-first priority with a starvation override that forces a pending fetch through.
module mem_arb_pick
    import rv_mem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = 3
) (
    input  logic             i_if_req,
    input  logic             i_d_req,
    input  logic [CNT_W-1:0] i_starve_cnt,
    output logic             o_grant,
    output logic             o_owner
);
    always_comb begin
        o_grant = i_if_req | i_d_req;
        o_owner = (i_if_req && (!i_d_req || i_starve_cnt == CNT_W'(STARVE_MAX))) ? OWN_IF : OWN_D;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction fetch and load/store onto one single-port RAM,
// absorbing the RAM read latency and stalling the core until its access completes.
module mem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk_btn,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    state_t           r_state;
    logic             r_owner;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [1:0]       r_lat_cnt;
    logic             w_grant;
    logic             w_owner;

    mem_arb_pick #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) u_pick (
        .i_if_req    (if_req),
        .i_d_req     (d_req),
        .i_starve_cnt(r_starve_cnt),
        .o_grant     (w_grant),
        .o_owner     (w_owner)
    );

    assign mem_en   = r_state == ST_ISSUE;
    assign if_valid = r_state == ST_RESP && r_owner == OWN_IF;
    assign d_valid  = r_state == ST_RESP && r_owner == OWN_D;
    assign stall    = (if_req & ~if_valid) | (d_req & ~d_valid);

    always_ff @(posedge clk_btn or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_IF;
            r_starve_cnt <= '0;
            r_lat_cnt    <= '0;
            mem_wen      <= 1'b0;
            mem_be       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_rdata     <= '0;
            d_rdata      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_grant) begin
                    r_owner  <= w_owner;
                    mem_addr <= w_owner == OWN_D ? d_addr : if_addr;
                    mem_be   <= w_owner == OWN_D ? d_be : 4'hf;
                    mem_wen  <= w_owner == OWN_D && d_wen;
                    if (w_owner == OWN_D) mem_wdata <= d_wdata;
                    // Counts data grants that overtook a waiting fetch; saturates at the override point.
                    r_starve_cnt <= (w_owner == OWN_D && if_req)
                        ? (r_starve_cnt == CNT_W'(STARVE_MAX) ? r_starve_cnt : r_starve_cnt + CNT_W'(1))
                        : '0;
                    r_state  <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    r_lat_cnt <= 2'(MEM_LAT);
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_lat_cnt <= r_lat_cnt - 2'd1;
                    if (r_lat_cnt == 2'd1) begin
                        if (r_owner == OWN_IF) if_rdata <= mem_rdata;
                        else if (!mem_wen) d_rdata <= mem_rdata;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run against a transaction-level RAM model.
module tb_mem_arbiter;
    localparam int SMAX = 4;

    logic clk_btn = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk_btn = ~clk_btn;

    logic        if_req = 0, d_req = 0, d_wen = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
    logic [3:0]  d_be = 0;

    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        if_valid1, d_valid1, mem_en1, mem_wen1, stall1;
    logic [3:0]  mem_be1;
    logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic        if_valid3, d_valid3, mem_en3, mem_wen3, stall3;
    logic [3:0]  mem_be3;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut (
        .clk_btn(clk_btn), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1), .if_valid(if_valid1),
        .d_req(d_req), .d_wen(d_wen), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata1), .d_valid(d_valid1),
        .mem_en(mem_en1), .mem_wen(mem_wen1), .mem_be(mem_be1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .stall(stall1)
    );

    mem_arbiter #(.ADDR_W(32), .MEM_LAT(3), .STARVE_MAX(SMAX)) dut3 (
        .clk_btn(clk_btn), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata3), .if_valid(if_valid3),
        .d_req(d_req), .d_wen(d_wen), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata3), .d_valid(d_valid3),
        .mem_en(mem_en3), .mem_wen(mem_wen3), .mem_be(mem_be3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .stall(stall3)
    );

    // RAM environment: read data is only valid exactly LAT cycles after mem_en, garbage otherwise.
    logic [31:0] ram1 [256];
    logic [31:0] ram3 [256];
    logic [31:0] rw1, rw3;
    int          rc1, rc3;

    always @(posedge clk_btn or negedge rst_n) begin
        if (!rst_n) rc1 <= 0;
        else begin
            rc1 <= mem_en1 ? 1 : (rc1 > 0 ? rc1 - 1 : 0);
            if (mem_en1) begin
                rw1 <= ram1[mem_addr1[9:2]];
                if (mem_wen1) for (int b = 0; b < 4; b++) if (mem_be1[b]) ram1[mem_addr1[9:2]][8*b+:8] <= mem_wdata1[8*b+:8];
            end
        end
    end
    always @(posedge clk_btn or negedge rst_n) begin
        if (!rst_n) rc3 <= 0;
        else begin
            rc3 <= mem_en3 ? 3 : (rc3 > 0 ? rc3 - 1 : 0);
            if (mem_en3) begin
                rw3 <= ram3[mem_addr3[9:2]];
                if (mem_wen3) for (int b = 0; b < 4; b++) if (mem_be3[b]) ram3[mem_addr3[9:2]][8*b+:8] <= mem_wdata3[8*b+:8];
            end
        end
    end
    assign mem_rdata1 = rc1 == 1 ? rw1 : 32'hBAD0_BAD0;
    assign mem_rdata3 = rc3 == 1 ? rw3 : 32'hBAD0_BAD0;

    logic        s_en1 [64], s_en3 [64], s_ifv1 [64], s_ifv3 [64], s_dv1 [64], s_stall1 [64], s_wen1 [64];
    logic [31:0] s_ifd1 [64], s_ifd3 [64], s_dd1 [64], s_addr1 [64], s_addr3 [64];
    logic [3:0]  s_be1 [64];

    // Records n cycles starting now (cycle 0); requesters drop req the cycle after their valid unless kept.
    task automatic run_cycles(input int n, input int sel, input bit keep_if, input bit keep_d);
        logic iv, dv;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_btn);
            s_en1[k] = mem_en1; s_en3[k] = mem_en3; s_ifv1[k] = if_valid1; s_ifv3[k] = if_valid3;
            s_dv1[k] = d_valid1; s_stall1[k] = stall1; s_wen1[k] = mem_wen1; s_be1[k] = mem_be1;
            s_ifd1[k] = if_rdata1; s_ifd3[k] = if_rdata3; s_dd1[k] = d_rdata1;
            s_addr1[k] = mem_addr1; s_addr3[k] = mem_addr3;
            iv = sel == 3 ? if_valid3 : if_valid1;
            dv = sel == 3 ? d_valid3 : d_valid1;
            @(posedge clk_btn); #1;
            if (iv && !keep_if) if_req = 0;
            if (dv && !keep_d) d_req = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 0; if_req = 0; d_req = 0;
        repeat (2) @(posedge clk_btn);
        @(negedge clk_btn); rst_n = 1;
        @(posedge clk_btn); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_btn);
        #1 rst_n = 0; #1;
        checks++;
        if ({mem_en1, mem_wen1, mem_be1, mem_addr1, mem_wdata1, if_valid1, d_valid1, if_rdata1, d_rdata1, stall1} !== '0) begin
            errors++; $display("FAIL reset_async: got en=%b wen=%b be=%h addr=%h ifv=%b dv=%b stall=%b required all 0", mem_en1, mem_wen1, mem_be1, mem_addr1, if_valid1, d_valid1, stall1);
        end
        @(posedge clk_btn); #1;
        checks++;
        if ({mem_en3, mem_wen3, mem_be3, mem_addr3, mem_wdata3, if_valid3, d_valid3, if_rdata3, d_rdata3} !== '0) begin
            errors++; $display("FAIL reset_held_lat3: got en=%b addr=%h required all 0", mem_en3, mem_addr3);
        end
        do_reset();
    endtask

    task automatic test_single_fetch();
        int n;
        do_reset();
        if_req = 1; if_addr = 32'h10;
        run_cycles(6, 1, 0, 0);
        n = 0;
        for (int k = 0; k < 6; k++) n += int'(s_en1[k]);
        checks++; if (s_en1[1] !== 1'b1 || n != 1) begin errors++; $display("FAIL fetch_mem_en: got en@1=%b count=%0d required 1/1", s_en1[1], n); end
        checks++; if (s_addr1[1] !== 32'h10) begin errors++; $display("FAIL fetch_addr: got %h required 00000010", s_addr1[1]); end
        checks++; if ({s_ifv1[2], s_ifv1[3]} !== 2'b01) begin errors++; $display("FAIL fetch_valid_cycle: got v2/v3=%b%b required 01", s_ifv1[2], s_ifv1[3]); end
        checks++; if (s_ifd1[3] !== 32'h13) begin errors++; $display("FAIL fetch_data: got %h required 00000013", s_ifd1[3]); end
        checks++; if ({s_stall1[0], s_stall1[1], s_stall1[2], s_stall1[3]} !== 4'b1110) begin
            errors++; $display("FAIL fetch_stall: got %b%b%b%b required 1110", s_stall1[0], s_stall1[1], s_stall1[2], s_stall1[3]);
        end
    endtask

    task automatic test_store_load();
        do_reset();
        d_req = 1; d_wen = 1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        run_cycles(5, 1, 0, 0);
        checks++; if ({s_en1[1], s_wen1[1], s_be1[1]} !== 6'b11_0011) begin errors++; $display("FAIL store_strobe: got en=%b wen=%b be=%b required 1 1 0011", s_en1[1], s_wen1[1], s_be1[1]); end
        checks++; if (s_dv1[3] !== 1'b1) begin errors++; $display("FAIL store_valid: got %b required 1", s_dv1[3]); end
        checks++; if (s_dd1[3] !== 32'h0) begin errors++; $display("FAIL store_rdata_kept: got %h required 00000000", s_dd1[3]); end
        d_req = 1; d_wen = 0; d_be = 4'hf;
        run_cycles(5, 1, 0, 0);
        checks++; if (s_dv1[3] !== 1'b1 || s_dd1[3] !== 32'h0000_BEEF) begin errors++; $display("FAIL load_after_store: got v=%b d=%h required 1 0000beef", s_dv1[3], s_dd1[3]); end
    endtask

    task automatic test_simultaneous();
        logic [9:0] st;
        do_reset();
        if_req = 1; if_addr = 32'h10; d_req = 1; d_wen = 0; d_be = 4'hf; d_addr = 32'h100;
        run_cycles(10, 1, 0, 0);
        checks++; if (s_dv1[3] !== 1'b1 || s_dd1[3] !== 32'h0000_BEEF) begin errors++; $display("FAIL simul_data_first: got v=%b d=%h required 1 0000beef", s_dv1[3], s_dd1[3]); end
        checks++; if (s_en1[5] !== 1'b1 || s_addr1[5] !== 32'h10) begin errors++; $display("FAIL simul_fetch_issue: got en=%b addr=%h required 1 00000010", s_en1[5], s_addr1[5]); end
        checks++; if (s_ifv1[7] !== 1'b1 || s_ifd1[7] !== 32'h13) begin errors++; $display("FAIL simul_fetch_done: got v=%b d=%h required 1 00000013", s_ifv1[7], s_ifd1[7]); end
        for (int k = 0; k < 10; k++) st[9-k] = s_stall1[k];
        checks++; if (st !== 10'b1111111000) begin errors++; $display("FAIL simul_stall: got %b required 1111111000", st); end
    endtask

    task automatic test_starvation();
        int dn0, dn1;
        logic [41:0] ivs, ive;
        do_reset();
        if_req = 1; if_addr = 32'h10; d_req = 1; d_wen = 0; d_be = 4'hf; d_addr = 32'h100;
        run_cycles(42, 1, 1, 1);
        dn0 = 0; dn1 = 0; ive = '0;
        for (int k = 0; k < 42; k++) begin
            ivs[k] = s_ifv1[k];
            if (k < 20) dn0 += int'(s_dv1[k]); else if (k < 40) dn1 += int'(s_dv1[k]);
        end
        ive[19] = 1'b1; ive[39] = 1'b1;
        checks++; if (dn0 != SMAX) begin errors++; $display("FAIL starve_first_run: got %0d data grants required %0d", dn0, SMAX); end
        checks++; if (ivs !== ive) begin errors++; $display("FAIL starve_fetch_slots: got %h required %h", ivs, ive); end
        checks++; if (dn1 != SMAX) begin errors++; $display("FAIL starve_cnt_cleared: got %0d data grants required %0d", dn1, SMAX); end
    endtask

    task automatic test_latency3();
        int n;
        do_reset();
        if_req = 1; if_addr = 32'h20;
        run_cycles(8, 3, 0, 0);
        n = 0;
        for (int k = 0; k < 8; k++) n += int'(s_en3[k]);
        checks++; if (s_en3[1] !== 1'b1 || n != 1 || s_addr3[1] !== 32'h20) begin errors++; $display("FAIL lat3_issue: got en@1=%b count=%0d addr=%h required 1/1/00000020", s_en3[1], n, s_addr3[1]); end
        checks++; if ({s_ifv3[4], s_ifv3[5]} !== 2'b01) begin errors++; $display("FAIL lat3_valid_cycle: got v4/v5=%b%b required 01", s_ifv3[4], s_ifv3[5]); end
        checks++; if (s_ifd3[5] !== 32'hCAFE_0020) begin errors++; $display("FAIL lat3_data: got %h required cafe0020", s_ifd3[5]); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        d_req = 1; d_wen = 0; d_be = 4'hf; d_addr = 32'h100;
        run_cycles(2, 1, 0, 0);
        @(negedge clk_btn);
        checks++; if (mem_addr1 !== 32'h100) begin errors++; $display("FAIL midreset_pre: got addr %h required 00000100", mem_addr1); end
        rst_n = 0; #1;
        checks++;
        if ({mem_en1, mem_wen1, mem_be1, mem_addr1, mem_wdata1, if_valid1, d_valid1, if_rdata1, d_rdata1} !== '0) begin
            errors++; $display("FAIL midreset_outputs: got en=%b be=%h addr=%h dv=%b d=%h required all 0", mem_en1, mem_be1, mem_addr1, d_valid1, d_rdata1);
        end
        d_req = 0;
        @(negedge clk_btn); rst_n = 1;
        @(posedge clk_btn); #1;
        run_cycles(6, 1, 0, 0);
        n = 0;
        for (int k = 0; k < 6; k++) n += int'(s_dv1[k]) + int'(s_en1[k]);
        checks++; if (n != 0) begin errors++; $display("FAIL midreset_no_valid: got %0d events required 0", n); end
        if_req = 1; if_addr = 32'h10;
        run_cycles(5, 1, 0, 0);
        checks++; if (s_ifv1[3] !== 1'b1 || s_ifd1[3] !== 32'h13) begin errors++; $display("FAIL midreset_fresh: got v=%b d=%h required 1 00000013", s_ifv1[3], s_ifd1[3]); end
    endtask

    // Transaction-level reference: serialized accesses against a model RAM, fairness bound, stall formula.
    task automatic test_random();
        logic [31:0] mram [256];
        logic [31:0] last_ld;
        int fpend, dpend, d_since_f, en_cnt, done_cnt, err0;
        logic iv, dv;
        do_reset();
        for (int i = 0; i < 256; i++) mram[i] = ram1[i];
        last_ld = 0; fpend = 0; dpend = 0; d_since_f = 0; en_cnt = 0; done_cnt = 0; err0 = errors;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc < 3800 && !if_req && $urandom_range(0, 3) == 0) begin
                if_req = 1; if_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if (cyc < 3800 && !d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_wen = 1'($urandom_range(0, 1)); d_be = 4'($urandom_range(1, 15));
                d_addr = 32'($urandom_range(0, 63)) << 2; d_wdata = $urandom;
            end
            @(negedge clk_btn);
            iv = if_valid1; dv = d_valid1;
            en_cnt += int'(mem_en1);
            checks++;
            if (stall1 !== ((if_req & ~iv) | (d_req & ~dv))) begin errors++; $display("FAIL rnd_stall cyc %0d: got %b required %b", cyc, stall1, (if_req & ~iv) | (d_req & ~dv)); end
            if (iv) begin
                done_cnt++; d_since_f = 0;
                checks++;
                if (!if_req || if_rdata1 !== mram[if_addr[9:2]]) begin errors++; $display("FAIL rnd_fetch cyc %0d: got %h required %h", cyc, if_rdata1, mram[if_addr[9:2]]); end
            end
            if (dv) begin
                done_cnt++;
                if (d_wen) begin
                    for (int b = 0; b < 4; b++) if (d_be[b]) mram[d_addr[9:2]][8*b+:8] = d_wdata[8*b+:8];
                    checks++;
                    if (d_rdata1 !== last_ld) begin errors++; $display("FAIL rnd_store_rdata cyc %0d: got %h required %h", cyc, d_rdata1, last_ld); end
                end else begin
                    checks++;
                    if (d_rdata1 !== mram[d_addr[9:2]]) begin errors++; $display("FAIL rnd_load cyc %0d: got %h required %h", cyc, d_rdata1, mram[d_addr[9:2]]); end
                    last_ld = mram[d_addr[9:2]];
                end
                if (if_req && !iv) begin
                    d_since_f++;
                    checks++;
                    if (d_since_f > SMAX + 1) begin errors++; $display("FAIL rnd_starve cyc %0d: got %0d data completions while fetch waits, required <= %0d", cyc, d_since_f, SMAX + 1); end
                end
            end
            fpend = (if_req && !iv) ? fpend + 1 : 0;
            dpend = (d_req && !dv) ? dpend + 1 : 0;
            if (fpend > 40 || dpend > 40) begin
                errors++; checks++; $display("FAIL rnd_timeout cyc %0d: fetch waited %0d, data waited %0d, required <= 40", cyc, fpend, dpend);
                break;
            end
            @(posedge clk_btn); #1;
            if (iv) if_req = 0;
            if (dv) d_req = 0;
        end
        checks++; if (if_req || d_req) begin errors++; $display("FAIL rnd_drain: got if_req=%b d_req=%b required 0 0", if_req, d_req); end
        checks++; if (en_cnt != done_cnt) begin errors++; $display("FAIL rnd_strobe_count: got %0d mem_en for %0d completions", en_cnt, done_cnt); end
        checks++; if (done_cnt < 200 && errors == err0) begin errors++; $display("FAIL rnd_activity: got %0d completions required >= 200", done_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin ram1[i] = 0; ram3[i] = 0; end
        ram1[4] = 32'h13; ram3[4] = 32'h13;
        ram1[8] = 32'hCAFE_0020; ram3[8] = 32'hCAFE_0020;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_simultaneous();
        test_starvation();
        test_latency3();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
